// File: rtl/fifo_rd_ctrl.sv
// Read-side controller for the dual-clock readout FIFO: write-pointer synchroniser,
// read pointer, empty/level flags and a prefetching valid/ready output register.
module fifo_rd_ctrl #(
  parameter int ASIZE    = 3,
  parameter int DSIZE    = 36,
  parameter int AE_LEVEL = 2
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic [ASIZE:0]   wptr_gray,
  output logic [ASIZE-1:0] raddr,
  input  logic [DSIZE-1:0] rdata,
  output logic [ASIZE:0]   rptr_gray,
  output logic             rempty,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   rcount,
  output logic [DSIZE-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready
);

  localparam logic [ASIZE:0] AE_THR = (ASIZE+1)'(AE_LEVEL);

  logic [ASIZE:0] rq1, rq2;
  logic [ASIZE:0] rbin, rbinnext, rgraynext;
  logic [ASIZE:0] wbin_sync, count_next;
  logic           rinc;

  function automatic logic [ASIZE:0] gray2bin(input logic [ASIZE:0] g);
    logic [ASIZE:0] b;
    b[ASIZE] = g[ASIZE];
    for (int i = ASIZE - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  assign raddr = rbin[ASIZE-1:0];

  // NOTE: every always_comb output is assigned on every path, so no latch can be inferred.
  always_comb begin
    rinc       = !rempty && (!dout_valid || dout_ready);
    rbinnext   = rbin + {{ASIZE{1'b0}}, rinc};
    rgraynext  = (rbinnext >> 1) ^ rbinnext;
    wbin_sync  = gray2bin(rq2);
    count_next = wbin_sync - rbinnext;
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rq1           <= '0;
      rq2           <= '0;
      rbin          <= '0;
      rptr_gray     <= '0;
      rempty        <= 1'b1;
      ralmost_empty <= 1'b1;
      rcount        <= '0;
      dout          <= '0;
      dout_valid    <= 1'b0;
    end else begin
      rq1           <= wptr_gray;
      rq2           <= rq1;
      rbin          <= rbinnext;
      rptr_gray     <= rgraynext;
      // Compared against the synchronised pointer only, so the flags can lag writes but never lead them.
      rempty        <= (rgraynext == rq2);
      rcount        <= count_next;
      ralmost_empty <= (count_next <= AE_THR);
      if (rinc) begin
        dout       <= rdata;
        dout_valid <= 1'b1;
      end else if (dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/fifo_rd_ctrl.md
Name: fifo_rd_ctrl

Overview:
- Read-side controller for the 8-deep x 36-bit dual-clock readout FIFO; pairs with the existing write-side memory and write-pointer logic.
- Synchronises the write pointer (Gray code) into the read clock domain and keeps the read pointer and empty flag.
- Drives the memory read address and prefetches words into an output register presented with a valid/ready handshake.
- Sits between the readout FIFO and the serializer/frame builder on the output-link clock.

Parameters:
ASIZE, 3, address width; FIFO depth = 2^ASIZE
DSIZE, 36, data word width
AE_LEVEL, 2, almost-empty threshold in words

Ports:
rclk  input  1  read-domain clock; all state updates on the rising edge
rrst  input  1  reset, asynchronous, active-high
wptr_gray  input  ASIZE+1  write pointer, Gray coded, from the write clock domain
raddr  output  ASIZE  memory read address (memory read is combinational)
rdata  input  DSIZE  memory read data for raddr
rptr_gray  output  ASIZE+1  read pointer, Gray coded, registered, to the write-domain full logic
rempty  output  1  FIFO memory empty, as seen in the read domain
ralmost_empty  output  1  rcount <= AE_LEVEL
rcount  output  ASIZE+1  words in memory, excluding the output register, 0..2^ASIZE
dout  output  DSIZE  output word
dout_valid  output  1  dout holds a valid word
dout_ready  input  1  consumer accepts dout this cycle

Behaviour:
- Reset (asynchronous, rrst=1) clears the following to 0: sync stages, rbin, rptr_gray, rcount, dout, dout_valid. It sets rempty=1 and ralmost_empty=1.
- Reset mid-transfer discards the word held in the output register. No residual valid is presented after reset.
- Synchroniser: two flops, rq1 <= wptr_gray, rq2 <= rq1. Only rq2 is used downstream.
- Read pointer: rbin is ASIZE+1 bits binary. raddr = rbin[ASIZE-1:0].
- rinc = !rempty && (!dout_valid || dout_ready).
- rbinnext = rbin + rinc, with wrap modulo 2^(ASIZE+1). rgraynext = (rbinnext>>1) ^ rbinnext. rptr_gray <= rgraynext.
- Empty flag: rempty <= (rgraynext == rq2), registered.
- Output register, priority order:
  - If rinc: dout <= rdata(raddr), dout_valid <= 1.
  - Else if dout_ready: dout_valid <= 0; dout holds its old value.
  - Else: hold dout and dout_valid.
- Throughput: one word per clock while not empty and dout_ready=1. Simultaneous consume and refill keeps dout_valid=1 with no bubble.
- dout is stable while dout_valid=1 and dout_ready=0.
- Latency from a wptr_gray change to the first dout_valid:
  - 2 rclk through the synchroniser, +1 for rempty to fall, +1 for dout_valid to rise, 4 rclk total.
- Count: wbin_sync is the Gray-to-binary conversion of rq2.
  - rcount <= (wbin_sync - rbinnext) mod 2^(ASIZE+1), registered.
  - Full memory gives rcount = 8 (MSBs differ, lower bits equal).
- ralmost_empty <= (count_next <= AE_LEVEL), registered.
- Wrap: the pointer wraps 15 -> 0 with no glitch in rempty or rcount. The Gray code changes one bit per increment.
- rempty=1 never issues a read. raddr is unchanged while rempty=1.
- Pessimism: rempty and rcount lag writes by synchroniser delay only. They never report data that has not been written.

Test Plan:
- Reset with rrst=1, then release -> rempty=1, dout_valid=0, rcount=0, rptr_gray=0, ralmost_empty=1.
- Step wptr_gray 0 -> 1 (word 0x123456789 at addr 0), dout_ready=0 -> rempty falls at rclk 3, dout_valid rises at rclk 4 with dout=0x123456789, rptr_gray=1, rempty returns to 1.
- Write 8 words (wptr_gray=Gray(8)=0xC), hold dout_ready=0 -> rcount=8 then 7 after prefetch. With dout_ready=1, words 0..7 stream on consecutive cycles in order, then dout_valid=0 and rempty=1.
- Run 20 write/read words through the FIFO -> rbin wraps 15 -> 0, data order preserved, rptr_gray sequence has exactly 1 bit change per step, and rempty does not glitch at the wrap.
- With dout_ready toggling 1,0,1,0 and 3 words available -> dout holds while ready=0, each word is accepted exactly once, and there is no duplication or loss.
- Assert rrst while dout_valid=1 and rcount=5 -> outputs return to reset values immediately without waiting for rclk. After release, behaviour is consistent with the current wptr_gray within 4 rclk.
